mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit output channel among N_INPUTS valid/ready requesters. It generates the select for the mux datapath internally and registers the selected beat into a one-entry output stage.
- Multi-beat bursts, delimited by a last flag, are never interleaved.
- Sits between producer ports and a shared downstream consumer (bus port, UART TX, memory write channel).

---
 rtl/mux_rr_arbiter_if.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle for the round-robin arbiter: N_INPUTS valid/ready
// input lanes with data and last, plus one registered output channel.
interface mux_rr_arbiter_if #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4
);
  localparam int SEL_W = $clog2(N_INPUTS);

  logic [N_INPUTS-1:0]       in_valid_i;
  logic [N_INPUTS*WIDTH-1:0] in_data_i;
  logic [N_INPUTS-1:0]       in_last_i;
  logic [N_INPUTS-1:0]       in_ready_o;
  logic                      out_valid_o;
  logic [WIDTH-1:0]          out_data_o;
  logic                      out_last_o;
  logic [SEL_W-1:0]          out_sel_o;
  logic                      out_ready_i;
  logic                      busy_o;

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o, out_sel_o, busy_o
  );

  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o, out_sel_o, busy_o
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 arbiter with burst lock and a one-entry registered output.
// The grant is a pure function of valids, ptr, lock state and output space.

module mux_rr_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             i_valid,
  input  logic             i_hit,
  input  logic             i_space,
  input  logic             i_last,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_last,
  output logic [WIDTH-1:0] o_data
);
  assign o_ready = i_hit & i_space & i_valid;
  // Non-selected lanes contribute zero so the mux reduces to an OR tree.
  assign o_last  = i_hit & i_last;
  assign o_data  = i_hit ? i_data : '0;
endmodule

module mux_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mux_rr_arbiter_if.slave      bus
);
  localparam int SEL_W = $clog2(N_INPUTS);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_lk;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_sel;

  logic                               w_busy;
  logic                               w_space;
  logic [SEL_W-1:0]                   w_scan_idx;
  logic [SEL_W-1:0]                   w_cand;
  logic [SEL_W-1:0]                   w_ptr_nxt;
  logic [N_INPUTS-1:0]                w_ready;
  logic [N_INPUTS-1:0]                w_lane_last;
  logic [N_INPUTS-1:0][WIDTH-1:0]     w_lane_data;
  logic [WIDTH-1:0]                   w_sel_data;
  logic                               w_sel_last;
  logic                               w_acc;

  assign w_busy  = (r_state == ST_LOCKED);
  assign w_space = !r_out_valid || bus.out_ready_i;

  // Walk from the highest offset down so the nearest valid requester at or
  // after ptr is the one left standing.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_scan_idx = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      v_idx = (int'(r_ptr) + i) % N_INPUTS;
      if (bus.in_valid_i[v_idx]) w_scan_idx = SEL_W'(v_idx);
    end
  end

  assign w_cand = w_busy ? r_lk : w_scan_idx;

  for (genvar k = 0; k < N_INPUTS; k++) begin : g_lane
    mux_rr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .i_valid (bus.in_valid_i[k]),
      .i_hit   (w_cand == SEL_W'(k)),
      .i_space (w_space),
      .i_last  (bus.in_last_i[k]),
      .i_data  (bus.in_data_i[k*WIDTH +: WIDTH]),
      .o_ready (w_ready[k]),
      .o_last  (w_lane_last[k]),
      .o_data  (w_lane_data[k])
    );
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_INPUTS; k++) w_sel_data = w_sel_data | w_lane_data[k];
  end

  assign w_sel_last = |w_lane_last;
  assign w_acc      = |(bus.in_valid_i & w_ready);
  assign w_ptr_nxt  = (w_cand == SEL_W'(N_INPUTS - 1)) ? '0 : w_cand + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_sel   <= w_cand;
    end else if (bus.out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Lock opens on a non-last beat and closes on the last; ptr only moves
  // at burst boundaries so a burst never costs its owner its turn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_UNLOCKED;
      r_lk    <= '0;
      r_ptr   <= '0;
    end else if (w_acc) begin
      if (w_sel_last) begin
        r_state <= ST_UNLOCKED;
        r_ptr   <= w_ptr_nxt;
      end else begin
        r_state <= ST_LOCKED;
        r_lk    <= w_cand;
      end
    end
  end

  assign bus.in_ready_o  = w_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_last_o  = r_out_last;
  assign bus.out_sel_o   = r_out_sel;
  assign bus.busy_o      = w_busy;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (4 x 8-bit): reset, round robin, burst
// lock, backpressure, wrap and reset mid-burst, plus a requester-stability monitor.
module tb_mux_rr_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk_i;
  logic rst_ni;
  int   n_tests;
  int   n_fail;
  logic mon_en;

  mux_rr_arbiter_if #(.WIDTH(W), .N_INPUTS(N)) bus ();

  mux_rr_arbiter #(.WIDTH(W), .N_INPUTS(N)) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int k, input logic v, input logic [W-1:0] d, input logic l);
    bus.in_valid_i[k]       = v;
    bus.in_data_i[k*W +: W] = d;
    bus.in_last_i[k]        = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d,
                         input logic [1:0] s);
    chk({tag, ".valid"}, {31'b0, bus.out_valid_o}, {31'b0, v});
    chk({tag, ".data"},  {24'b0, bus.out_data_o},  {24'b0, d});
    chk({tag, ".sel"},   {30'b0, bus.out_sel_o},   {30'b0, s});
  endtask

  // A requester holding valid without a handshake must keep valid/data/last stable.
  logic [N-1:0]       p_pend;
  logic [N*W-1:0]     p_data;
  logic [N-1:0]       p_last;
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      p_pend = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (mon_en && p_pend[k]) begin
          chk($sformatf("proto%0d", k),
              {23'b0, bus.in_valid_i[k], bus.in_last_i[k], bus.in_data_i[k*W +: W]},
              {23'b0, 1'b1, p_last[k], p_data[k*W +: W]});
        end
      end
      p_pend = bus.in_valid_i & ~bus.in_ready_o;
      p_data = bus.in_data_i;
      p_last = bus.in_last_i;
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b1;
    rst_ni  = 1'b0;
    bus.in_valid_i  = '0;
    bus.in_data_i   = '0;
    bus.in_last_i   = '0;
    bus.out_ready_i = 1'b1;

    // Reset state
    step(); step();
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.last",  {31'b0, bus.out_last_o}, 32'd0);
    chk("rst.busy",  {31'b0, bus.busy_o},     32'd0);
    chk("rst.ready", {28'b0, bus.in_ready_o}, 32'd0);
    rst_ni = 1'b1;
    step();

    // Single requester: port 2, ptr 0 -> 3
    set_port(2, 1'b1, 8'h5A, 1'b1);
    #1 chk("single.ready", {28'b0, bus.in_ready_o}, 32'b0100);
    step();
    chk_out("single", 1'b1, 8'h5A, 2'd2);
    chk("single.last", {31'b0, bus.out_last_o}, 32'd1);
    set_port(2, 1'b0, 8'h00, 1'b0);
    #1 chk("idle.ready", {28'b0, bus.in_ready_o}, 32'd0);
    step();
    chk_out("drain", 1'b0, 8'h5A, 2'd2);

    // Wrap: ptr 3, ports 3 and 0 -> 3 then 0
    set_port(3, 1'b1, 8'h33, 1'b1);
    set_port(0, 1'b1, 8'h30, 1'b1);
    #1 chk("wrap.ready0", {28'b0, bus.in_ready_o}, 32'b1000);
    step();
    chk_out("wrap.b0", 1'b1, 8'h33, 2'd3);
    set_port(3, 1'b0, 8'h00, 1'b0);
    #1 chk("wrap.ready1", {28'b0, bus.in_ready_o}, 32'b0001);
    step();
    chk_out("wrap.b1", 1'b1, 8'h30, 2'd0);
    set_port(0, 1'b0, 8'h00, 1'b0);
    // ptr is 1; a lone port-3 beat moves it to 0
    set_port(3, 1'b1, 8'h3F, 1'b1);
    #1 chk("solo3.ready", {28'b0, bus.in_ready_o}, 32'b1000);
    step();
    chk_out("solo3", 1'b1, 8'h3F, 2'd3);

    // Round robin from ptr 0, 1 beat/cycle
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 8'hA0 + 8'(k), 1'b1);
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr%0d.ready", i), {28'b0, bus.in_ready_o}, 32'(1 << (i % 4)));
      step();
      chk_out($sformatf("rr%0d", i), 1'b1, 8'hA0 + 8'(i % 4), 2'(i % 4));
    end

    // Backpressure 5 cycles, then drain+load with no bubble (ptr 2)
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("bp%0d.ready", i), {28'b0, bus.in_ready_o}, 32'd0);
      step();
      chk_out($sformatf("bp%0d", i), 1'b1, 8'hA1, 2'd1);
    end
    bus.out_ready_i = 1'b1;
    #1 chk("bp.rel.ready", {28'b0, bus.in_ready_o}, 32'b0100);
    step();
    chk_out("bp.rel", 1'b1, 8'hA2, 2'd2);
    mon_en = 1'b0;
    for (int k = 0; k < N; k++) set_port(k, 1'b0, 8'h00, 1'b0);
    step();
    chk("bp.empty", {31'b0, bus.out_valid_o}, 32'd0);
    mon_en = 1'b1;

    // Burst lock on port 1 (ptr 3), port 0 waiting
    set_port(1, 1'b1, 8'h11, 1'b0);
    #1 chk("burst.r0", {28'b0, bus.in_ready_o}, 32'b0010);
    step();
    chk_out("burst.b0", 1'b1, 8'h11, 2'd1);
    chk("burst.busy0", {31'b0, bus.busy_o}, 32'd1);
    set_port(1, 1'b0, 8'h00, 1'b0);
    set_port(0, 1'b1, 8'h0A, 1'b1);
    #1 chk("lockidle.ready", {28'b0, bus.in_ready_o}, 32'd0);
    step();
    chk("lockidle.busy",  {31'b0, bus.busy_o},      32'd1);
    chk("lockidle.valid", {31'b0, bus.out_valid_o}, 32'd0);
    set_port(1, 1'b1, 8'h12, 1'b0);
    #1 chk("burst.r1", {28'b0, bus.in_ready_o}, 32'b0010);
    step();
    chk_out("burst.b1", 1'b1, 8'h12, 2'd1);
    set_port(1, 1'b1, 8'h13, 1'b1);
    #1 chk("burst.r2", {28'b0, bus.in_ready_o}, 32'b0010);
    step();
    chk_out("burst.b2", 1'b1, 8'h13, 2'd1);
    chk("burst.last",  {31'b0, bus.out_last_o}, 32'd1);
    chk("burst.busy2", {31'b0, bus.busy_o},     32'd0);
    // ptr 2: port 3 beats port 0
    set_port(1, 1'b0, 8'h00, 1'b0);
    set_port(3, 1'b1, 8'h3B, 1'b1);
    #1 chk("post.ready", {28'b0, bus.in_ready_o}, 32'b1000);
    step();
    chk_out("post.b", 1'b1, 8'h3B, 2'd3);
    set_port(3, 1'b0, 8'h00, 1'b0);
    #1 chk("post0.ready", {28'b0, bus.in_ready_o}, 32'b0001);
    step();
    chk_out("post0.b", 1'b1, 8'h0A, 2'd0);

    // Reset while locked on port 2 with a pending output beat
    set_port(0, 1'b0, 8'h00, 1'b0);
    set_port(2, 1'b1, 8'h21, 1'b0);
    #1 chk("rb.ready", {28'b0, bus.in_ready_o}, 32'b0100);
    step();
    chk_out("rb.b0", 1'b1, 8'h21, 2'd2);
    chk("rb.busy", {31'b0, bus.busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_out("rb.rst", 1'b0, 8'h00, 2'd0);
    chk("rb.rst.busy", {31'b0, bus.busy_o},     32'd0);
    chk("rb.rst.last", {31'b0, bus.out_last_o}, 32'd0);
    set_port(2, 1'b0, 8'h00, 1'b0);
    set_port(0, 1'b1, 8'h01, 1'b1);
    set_port(1, 1'b1, 8'h02, 1'b1);
    step();
    rst_ni = 1'b1;
    #1 chk("rb.after.ready", {28'b0, bus.in_ready_o}, 32'b0001);
    step();
    chk_out("rb.after", 1'b1, 8'h01, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
